// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot/one-cold decoder with a prescaled auto-scan
// mode and an end-of-scan wrap strobe. Each output bit is its own lane register.

module decoder_nto2n_lane #(
  parameter int N          = 2,
  parameter int K          = 0,
  parameter int ACTIVE_LOW = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] idx_next,
  output logic         y
);
  localparam logic [N-1:0] SEL   = N'(K);
  localparam logic         INACT = 1'(ACTIVE_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y <= INACT;
    else        y <= (en && idx_next == SEL) ? ~INACT : INACT;
  end
endmodule

module decoder_nto2n_seq #(
  parameter int N          = 2,
  parameter int DIV        = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [N-1:0]       sel,
  output logic [(1<<N)-1:0]  y,
  output logic [N-1:0]       idx,
  output logic               wrap
);
  localparam int NO = 1 << N;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PC_TC  = PW'(DIV - 1);
  localparam logic [PW-1:0] PC_ONE = PW'(1);
  localparam logic [N-1:0]  IX_ONE = N'(1);

  if (N < 1 || N > 6) begin : g_bad_n
    $error("decoder_nto2n_seq: N must be in 1..6");
  end
  if (DIV < 1) begin : g_bad_div
    $error("decoder_nto2n_seq: DIV must be >= 1");
  end

  typedef struct packed {
    logic [N-1:0]  idx;
    logic [PW-1:0] pc;
    logic          wrap;
  } seq_st_t;

  seq_st_t st_q, st_d;

  always_comb begin
    st_d      = st_q;
    st_d.wrap = 1'b0;
    if (load) begin
      st_d.idx = sel;
      st_d.pc  = '0;
    end else if (mode && en) begin
      if (st_q.pc == PC_TC) begin
        st_d.pc   = '0;
        st_d.idx  = st_q.idx + IX_ONE;
        st_d.wrap = &st_q.idx;
      end else begin
        st_d.pc   = st_q.pc + PC_ONE;
      end
    end else if (!mode) begin
      st_d.pc = '0;
    end
    // mode=1, en=0: prescaler and index hold so the scan resumes mid-period
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  assign idx  = st_q.idx;
  assign wrap = st_q.wrap;

  // Lanes decode the next index so y and idx change on the same edge
  for (genvar k = 0; k < NO; k++) begin : g_lane
    decoder_nto2n_lane #(
      .N          (N),
      .K          (k),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .idx_next (st_d.idx),
      .y        (y[k])
    );
  end
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Randomized + directed bench for decoder_nto2n_seq; two instances cover
// active-high/prescaled and active-low/DIV=1 configurations.

module tb_decoder_nto2n_seq;
  localparam int N0 = 2, D0 = 3, A0 = 0;
  localparam int N1 = 3, D1 = 1, A1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en, mode, load;
  logic [N0-1:0] sel0;
  logic [N1-1:0] sel1;
  logic [(1<<N0)-1:0] y0;
  logic [(1<<N1)-1:0] y1;
  logic [N0-1:0] idx0;
  logic [N1-1:0] idx1;
  logic wrap0, wrap1;

  int checks = 0;
  int errors = 0;
  int m_idx[2], m_pc[2], m_wrap[2], m_y[2];
  int en_prev;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.N(N0), .DIV(D0), .ACTIVE_LOW(A0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .sel(sel0), .y(y0), .idx(idx0), .wrap(wrap0));

  decoder_nto2n_seq #(.N(N1), .DIV(D1), .ACTIVE_LOW(A1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .sel(sel1), .y(y1), .idx(idx1), .wrap(wrap1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idx[i] = 0; m_pc[i] = 0; m_wrap[i] = 0;
    end
    m_y[0] = (A0 != 0) ? (1 << (1 << N0)) - 1 : 0;
    m_y[1] = (A1 != 0) ? (1 << (1 << N1)) - 1 : 0;
    en_prev = 0;
  endtask

  // Behavioural model: integer index and prescaler count straight from the rules
  task automatic model_step(input int i, input int nn, input int dd, input int al, input int s);
    int top  = (1 << nn) - 1;
    int mask = (1 << (1 << nn)) - 1;
    if (load) begin
      m_idx[i] = s; m_pc[i] = 0; m_wrap[i] = 0;
    end else if (mode && en) begin
      if (m_pc[i] == dd - 1) begin
        m_pc[i]   = 0;
        m_wrap[i] = (m_idx[i] == top) ? 1 : 0;
        m_idx[i]  = (m_idx[i] + 1) % (top + 1);
      end else begin
        m_pc[i]++;
        m_wrap[i] = 0;
      end
    end else begin
      if (!mode) m_pc[i] = 0;
      m_wrap[i] = 0;
    end
    if (en) m_y[i] = (al != 0) ? (~(1 << m_idx[i])) & mask : (1 << m_idx[i]);
    else    m_y[i] = (al != 0) ? mask : 0;
  endtask

  task automatic check_all();
    chk("y0", 32'(y0), 32'(m_y[0]));
    chk("idx0", 32'(idx0), 32'(m_idx[0]));
    chk("wrap0", 32'(wrap0), 32'(m_wrap[0]));
    chk("hot0", 32'($countones(y0)), 32'(en_prev));
    chk("y1", 32'(y1), 32'(m_y[1]));
    chk("idx1", 32'(idx1), 32'(m_idx[1]));
    chk("wrap1", 32'(wrap1), 32'(m_wrap[1]));
    chk("hot1", 32'($countones(~y1)), 32'(en_prev));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, N0, D0, A0, int'(sel0));
    model_step(1, N1, D1, A1, int'(sel1));
    en_prev = en ? 1 : 0;
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_y0"}, 32'(y0), 32'h0);
    chk({tag, "_y1"}, 32'(y1), 32'hFF);
    chk({tag, "_idx0"}, 32'(idx0), 32'h0);
    chk({tag, "_idx1"}, 32'(idx1), 32'h0);
    chk({tag, "_wrap0"}, 32'(wrap0), 32'h0);
    chk({tag, "_wrap1"}, 32'(wrap1), 32'h0);
  endtask

  // Called just after a step: reset lands between edges, checked with no edge
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("areset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel0 = '0; sel1 = '0;
    model_reset();
    #12 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    // direct load and hold
    en = 1'b1; mode = 1'b0; load = 1'b1; sel0 = 2; sel1 = 5;
    run(1);
    chk("load_y0", 32'(y0), 32'h4);
    chk("load_y1", 32'(y1), 32'hDF);
    load = 1'b0;
    run(3);

    // full scan from idx 0, covering wrap on both instances
    load = 1'b1; sel0 = 0; sel1 = 0; mode = 1'b1;
    run(1);
    load = 1'b0;
    run(14);

    // en dropped mid-period with pc=1
    load = 1'b1; sel0 = 0; sel1 = 0;
    run(1);
    load = 1'b0;
    run(1);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(4);

    // load coincident with terminal count
    load = 1'b1; sel0 = 3; sel1 = 7;
    run(1);
    load = 1'b0;
    run(2);
    load = 1'b1; sel0 = 1; sel1 = 1;
    run(1);
    chk("tc_load_idx0", 32'(idx0), 32'h1);
    chk("tc_load_wrap0", 32'(wrap0), 32'h0);
    load = 1'b0;
    run(3);

    // mode 1->0 at pc=DIV-2, hold, then back to scan
    load = 1'b1; sel0 = 0; sel1 = 0;
    run(1);
    load = 1'b0;
    run(1);
    mode = 1'b0;
    run(4);
    mode = 1'b1;
    run(4);

    async_reset();

    for (int k = 0; k < 800; k++) begin
      load = ($urandom_range(0, 9) == 0);
      mode = ($urandom_range(0, 5) != 0);
      en   = ($urandom_range(0, 7) != 0);
      sel0 = N0'($urandom);
      sel1 = N1'($urandom);
      step();
      if (k == 400) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
